serial_shift_rx: RTL and testbench

//  Receiving end of the 3-wire serial display bus (shift clock, shift data, load enable) that the
//  LED and 7-segment drivers transmit toward the board's shift-register chains.

---
 rtl/serial_shift_rx_if.sv | 26 ++
 rtl/serial_shift_rx.sv | 158 +++++++++++++++
 tb/tb_serial_shift_rx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/serial_shift_rx_if.sv
// Display-bus wires (sclk/sdata/spen) plus the receiver's frame outputs.
// master drives the wires and observes results; slave is the receiver.
interface serial_shift_rx_if #(
    parameter int WIDTH = 64
) ();
    localparam int CW = $clog2(WIDTH + 1);

    logic             sclk;
    logic             sdata;
    logic             spen;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             frame_err;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;

    modport master (
        output sclk, sdata, spen,
        input  data_out, data_valid, frame_err, bit_cnt, overrun
    );

    modport slave (
        input  sclk, sdata, spen,
        output data_out, data_valid, frame_err, bit_cnt, overrun
    );
endinterface

// File: rtl/serial_shift_rx.sv
// Display-bus receiver: syncs sclk/sdata/spen, shifts MSB-first, latches WIDTH-bit frame on spen rise.
// Edge-to-action 3 clk; no backpressure. Optional SHIFT idle abort under `define SSRX_TIMEOUT_EN.
module serial_shift_rx #(
    parameter int WIDTH       = 64
`ifdef SSRX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic               clk,
    input  logic               rst,
    serial_shift_rx_if.slave   bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [2:0]       sclk_sync;
    logic [1:0]       sdata_sync;
    logic [2:0]       spen_sync;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             long_q, long_nxt;
    logic [WIDTH-1:0] dout, dout_nxt;
    logic             valid_q, valid_nxt;
    logic             err_q, err_nxt;
    logic             ovr_q, ovr_nxt;
    logic             shift_en;
    logic             sclk_rise, spen_rise, sdata_s2, spen_s2;

`ifdef SSRX_TIMEOUT_EN
    localparam int            IW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] TO_MAX = IW'(TIMEOUT_CYC - 1);
    logic [IW-1:0] idle_cnt, idle_nxt;
`endif

    // spen synchroniser presets high so a low wire after reset is not seen as a load edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync  <= 3'b000;
            sdata_sync <= 2'b00;
            spen_sync  <= 3'b111;
        end else begin
            sclk_sync  <= {sclk_sync[1:0], bus.sclk};
            sdata_sync <= {sdata_sync[0], bus.sdata};
            spen_sync  <= {spen_sync[1:0], bus.spen};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign spen_rise = spen_sync[1] & ~spen_sync[2];
    assign sdata_s2  = sdata_sync[1];
    assign spen_s2   = spen_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            long_q  <= 1'b0;
            dout    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            sr      <= sr_nxt;
            cnt     <= cnt_nxt;
            long_q  <= long_nxt;
            dout    <= dout_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
            ovr_q   <= ovr_nxt;
        end
    end

`ifdef SSRX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) idle_cnt <= '0;
        else     idle_cnt <= idle_nxt;
    end
`endif

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        long_nxt  = long_q;
        dout_nxt  = dout;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        ovr_nxt   = ovr_q;
        shift_en  = 1'b0;
`ifdef SSRX_TIMEOUT_EN
        idle_nxt  = '0;
`endif

        case (state)
            IDLE: begin
                if (spen_rise) begin
                    err_nxt = 1'b1;
                end else if (sclk_rise && !spen_s2) begin
                    shift_en  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // a bit arriving together with the load edge still belongs to this frame
                shift_en = sclk_rise;
            end
            default: state_nxt = IDLE;
        endcase

        if (shift_en) begin
            sr_nxt = {sr[WIDTH-2:0], sdata_s2};
            if (cnt == FULL) begin
                ovr_nxt  = 1'b1;
                long_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end

        if (state == SHIFT) begin
`ifdef SSRX_TIMEOUT_EN
            idle_nxt = sclk_rise ? '0 : idle_cnt + 1'b1;
`endif
            if (spen_rise) begin
                if (cnt_nxt == FULL && !long_nxt) begin
                    dout_nxt  = sr_nxt;
                    valid_nxt = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
                cnt_nxt   = '0;
                long_nxt  = 1'b0;
                state_nxt = IDLE;
            end
`ifdef SSRX_TIMEOUT_EN
            else if (!sclk_rise && idle_cnt == TO_MAX) begin
                err_nxt   = 1'b1;
                cnt_nxt   = '0;
                long_nxt  = 1'b0;
                state_nxt = IDLE;
            end
`endif
        end
    end

    assign bus.data_out   = dout;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = err_q;
    assign bus.bit_cnt    = cnt;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_serial_shift_rx.sv
// Scoreboarded bench for serial_shift_rx: frames are modelled as bit lists, expectations queued per frame.
module tb_serial_shift_rx;
    localparam int WIDTH = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_shift_rx_if #(.WIDTH(WIDTH)) bus ();
    serial_shift_rx #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit               is_valid;
        logic [WIDTH-1:0] data;
        bit               ovr;
    } exp_t;

    exp_t             exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [WIDTH-1:0] last_good;
    bit               ovr_model;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input bit v);
        exp_t e;
        e.is_valid = v;
        e.data     = last_good;
        e.ovr      = ovr_model;
        exp_q.push_back(e);
    endtask

    // monitor: every output pulse is matched against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.data_valid || bus.frame_err) begin
            check("pulse_exclusive", {127'd0, bus.data_valid & bus.frame_err}, 128'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b, expected no pulse",
                         bus.data_valid, bus.frame_err);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_valid", {127'd0, bus.data_valid}, {127'd0, e.is_valid});
                check("data_out", {64'd0, bus.data_out}, {64'd0, e.data});
                check("bit_cnt_after_frame", {121'd0, bus.bit_cnt}, 128'd0);
                check("overrun_at_pulse", {127'd0, bus.overrun}, {127'd0, e.ovr});
            end
        end
    end

    task automatic send_bit(input bit b, input bit with_load);
        bus.sdata = b;
        cyc(4);
        bus.sclk = 1'b1;
        if (with_load) bus.spen = 1'b1;
        cyc(4);
        bus.sclk = 1'b0;
        cyc(4);
    endtask

    // bits[n-1] goes first; a good frame is exactly WIDTH bits, anything else is an error
    task automatic frame(input int n, input logic [127:0] bits, input bit simul);
        if (n > WIDTH) ovr_model = 1'b1;
        if (n == WIDTH) begin
            last_good = bits[WIDTH-1:0];
            push_exp(1'b1);
        end else begin
            push_exp(1'b0);
        end
        bus.spen = 1'b0;
        cyc(4);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i], simul && (i == 0));
        bus.spen = 1'b1;
        cyc(8);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data_out"}, {64'd0, bus.data_out}, 128'd0);
        check({tag, "_data_valid"}, {127'd0, bus.data_valid}, 128'd0);
        check({tag, "_frame_err"}, {127'd0, bus.frame_err}, 128'd0);
        check({tag, "_bit_cnt"}, {121'd0, bus.bit_cnt}, 128'd0);
        check({tag, "_overrun"}, {127'd0, bus.overrun}, 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] bits;
        int           n;
        bus.sclk  = 1'b0;
        bus.sdata = 1'b0;
        bus.spen  = 1'b1;
        rst       = 1'b1;
        last_good = '0;
        ovr_model = 1'b0;
        cyc(5);
        check_reset_vals("reset");
        rst = 1'b0;
        cyc(5);

        frame(WIDTH, 128'h0123_4567_89AB_CDEF, 1'b0);
        frame(WIDTH - 1, rnd128(), 1'b0);
        check("overrun_after_short", {127'd0, bus.overrun}, 128'd0);
        frame(WIDTH + 2, {62'd0, 2'b11, 64'hFFFF_0000_FFFF_0000}, 1'b0);
        check("overrun_after_long", {127'd0, bus.overrun}, 128'd1);
        frame(WIDTH, rnd128(), 1'b0);
        check("overrun_sticky", {127'd0, bus.overrun}, 128'd1);
        frame(WIDTH, rnd128(), 1'b1);

        // reset in the middle of a frame
        bus.spen = 1'b0;
        cyc(4);
        for (int i = 0; i < 30; i++) send_bit(1'($urandom), 1'b0);
        check("bit_cnt_mid_frame", {121'd0, bus.bit_cnt}, 128'd30);
        rst = 1'b1;
        cyc(4);
        check_reset_vals("midreset");
        rst       = 1'b0;
        last_good = '0;
        ovr_model = 1'b0;
        cyc(4);
        frame(WIDTH, 128'hA5A5_A5A5_5A5A_5A5A, 1'b0);

        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 5))
                0, 1:    n = WIDTH;
                2:       n = WIDTH - 1 - $urandom_range(0, 3);
                3:       n = WIDTH + 1 + $urandom_range(0, 4);
                4:       n = 0;
                default: n = $urandom_range(1, WIDTH - 1);
            endcase
            bits = rnd128();
            frame(n, bits, (n > 0) && ($urandom_range(0, 1) == 1));
        end
        cyc(10);
        check("overrun_model", {127'd0, bus.overrun}, {127'd0, ovr_model});

        // ten bits then silence
        bus.spen = 1'b0;
        cyc(4);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0);
`ifdef SSRX_TIMEOUT_EN
        push_exp(1'b0);
        cyc(4200);
        check("bit_cnt_after_timeout", {121'd0, bus.bit_cnt}, 128'd0);
`else
        cyc(4200);
        check("bit_cnt_no_timeout", {121'd0, bus.bit_cnt}, 128'd10);
`endif
        check("queue_drained_silence", 128'(exp_q.size()), 128'd0);
        push_exp(1'b0);
        bus.spen = 1'b1;
        cyc(20);
        check("queue_drained_end", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
